// File: rtl/data_sram_bridge.sv
// rtl/data_sram_bridge.sv - CPU data port to request/handshake SRAM bridge
//
// Purpose:
//   Turns a single-cycle CPU data access into one SRAM-like transaction
//   (request phase gated by mem_addr_ok, data phase gated by mem_data_ok)
//   and stalls the CPU until that transaction completes. Only one
//   transaction is outstanding at a time.
//
// Optional feature:
//   DATA_SRAM_BRIDGE_LOADEXT_EN - when defined, load data is lane-selected
//   by the access size and the low address bits, then sign- or
//   zero-extended. When undefined, cpu_rdata is the raw memory word and
//   cpu_rsign is unused.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   cpu_en          data access request from the memory stage
//   cpu_wen[3:0]    byte write mask (0 = load)
//   cpu_addr[31:0]  byte address
//   cpu_wdata[31:0] store data, lanes already replicated
//   cpu_rwidth[3:0] load width: 0001 byte, 0011 half, 1111 word
//   cpu_rsign       sign-extend a byte/half load
//   pipe_stall      stall coming from the rest of the pipeline
//   cpu_rdata[31:0] load result (registered)
//   cpu_stall       pipeline stall caused by this bridge
//   mem_req         request valid (address phase)
//   mem_wr          1 = write
//   mem_size[1:0]   0 byte, 1 half, 2 word
//   mem_addr[31:0]  request address
//   mem_wdata[31:0] write data
//   mem_addr_ok     request accepted
//   mem_data_ok     read data valid / write complete
//   mem_rdata[31:0] read data

module data_sram_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_rwidth,
  input  logic        cpu_rsign,
  input  logic        pipe_stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        done_q, done_d;
  logic        mem_wr_q, mem_wr_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] load_data;

  // Writes take their size from the byte mask, reads from the width code;
  // anything unrecognised falls back to a full word.
  function automatic logic [1:0] size_code(input logic [3:0] wen,
                                           input logic [3:0] rwidth);
    logic [1:0] s;
    if (|wen) begin
      case (wen)
        4'b0001, 4'b0010, 4'b0100, 4'b1000: s = 2'd0;
        4'b0011, 4'b1100:                   s = 2'd1;
        default:                            s = 2'd2;
      endcase
    end else begin
      case (rwidth)
        4'b0001: s = 2'd0;
        4'b0011: s = 2'd1;
        default: s = 2'd2;
      endcase
    end
    return s;
  endfunction

`ifdef DATA_SRAM_BRIDGE_LOADEXT_EN
  logic rsign_q, rsign_d;

  // The registered mem_size already encodes the load width, and the low
  // bits of the registered address give the lane.
  function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size,
                                              input logic        sign);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    shifted = raw >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? raw[31:16] : raw[15:0];
    case (size)
      2'd0:    r = {{24{sign & b[7]}}, b};
      2'd1:    r = {{16{sign & h[15]}}, h};
      default: r = raw;
    endcase
    return r;
  endfunction

  assign load_data = load_extend(mem_rdata, mem_addr_q[1:0], mem_size_q, rsign_q);
`else
  logic unused_rsign;
  assign unused_rsign = cpu_rsign;
  assign load_data    = mem_rdata;
`endif

  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    mem_wr_d    = mem_wr_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
`ifdef DATA_SRAM_BRIDGE_LOADEXT_EN
    rsign_d     = rsign_q;
`endif
    case (state_q)
      S_IDLE: begin
        // done keeps the finished access from being re-issued until the
        // pipeline actually moves past it.
        if (done_q && !pipe_stall) begin
          done_d = 1'b0;
        end
        if (cpu_en && !done_q) begin
          state_d     = S_ADDR;
          mem_wr_d    = |cpu_wen;
          mem_size_d  = size_code(cpu_wen, cpu_rwidth);
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
`ifdef DATA_SRAM_BRIDGE_LOADEXT_EN
          rsign_d     = cpu_rsign;
`endif
        end
      end
      S_ADDR: begin
        if (mem_addr_ok) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (mem_data_ok) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (!mem_wr_q) begin
            cpu_rdata_d = load_data;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      done_q      <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_size_q  <= 2'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      cpu_rdata_q <= 32'd0;
`ifdef DATA_SRAM_BRIDGE_LOADEXT_EN
      rsign_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      mem_wr_q    <= mem_wr_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
`ifdef DATA_SRAM_BRIDGE_LOADEXT_EN
      rsign_q     <= rsign_d;
`endif
    end
  end

  assign mem_req   = (state_q == S_ADDR);
  assign mem_wr    = mem_wr_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_stall = cpu_en & ~done_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// tb/tb_data_sram_bridge.sv - self-checking bench for data_sram_bridge

module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_rwidth;
  logic        cpu_rsign;
  logic        pipe_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  data_sram_bridge dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_en      (cpu_en),
    .cpu_wen     (cpu_wen),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rwidth  (cpu_rwidth),
    .cpu_rsign   (cpu_rsign),
    .pipe_stall  (pipe_stall),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_size    (mem_size),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // expectations written by the stimulus, consumed by the compare process
  logic        chk_en = 1'b0;
  logic        exp_stall;
  logic        exp_req;
  logic        exp_chk_fields;
  logic        exp_wr;
  logic [1:0]  exp_size;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  logic [31:0] exp_rdata;

  int stall_cycles = 0;
  int req_cycles   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // access size as the memory side must see it
  function automatic logic [1:0] model_size(input logic [3:0] wen, input logic [3:0] rwidth);
    if (wen != 4'd0) begin
      if (wen == 4'hF) return 2'd2;
      if (wen == 4'h3 || wen == 4'hC) return 2'd1;
      if ($countones(wen) == 1) return 2'd0;
      return 2'd2;
    end
    if (rwidth == 4'h1) return 2'd0;
    if (rwidth == 4'h3) return 2'd1;
    return 2'd2;
  endfunction

  // value the CPU must see for a load of 'raw'
  function automatic logic [31:0] model_load(input logic [31:0] raw, input logic [31:0] addr,
                                             input logic [3:0] rwidth, input logic rsign);
    logic [31:0] v;
    v = raw;
`ifdef DATA_SRAM_BRIDGE_LOADEXT_EN
    if (rwidth == 4'h1) begin
      v = (raw >> (addr[1:0] * 8)) & 32'hFF;
      if (rsign && v[7]) v = v | 32'hFFFFFF00;
    end else if (rwidth == 4'h3) begin
      v = addr[1] ? (raw >> 16) : (raw & 32'hFFFF);
      if (rsign && v[15]) v = v | 32'hFFFF0000;
    end
`endif
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (cpu_stall) stall_cycles++;
      if (mem_req) req_cycles++;
      check("cpu_stall", {31'd0, cpu_stall}, {31'd0, exp_stall});
      check("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
      check("cpu_rdata", cpu_rdata, exp_rdata);
      if (exp_chk_fields) begin
        check("mem_wr", {31'd0, mem_wr}, {31'd0, exp_wr});
        check("mem_size", {30'd0, mem_size}, {30'd0, exp_size});
        check("mem_addr", mem_addr, exp_addr);
        check("mem_wdata", mem_wdata, exp_wdata);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // one complete access: aw extra cycles before addr_ok, dw extra cycles
  // before data_ok, ps cycles of pipe_stall after completion
  task automatic txn(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] rwidth, input logic rsign, input int aw, input int dw,
                     input logic [31:0] rdata, input int ps);
    cpu_en = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
    cpu_rwidth = rwidth; cpu_rsign = rsign; pipe_stall = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    exp_stall = 1'b1; exp_req = 1'b0; exp_chk_fields = 1'b0;
    step;
    exp_req = 1'b1; exp_chk_fields = 1'b1; exp_wr = |wen;
    exp_size = model_size(wen, rwidth); exp_addr = addr; exp_wdata = wdata;
    for (int i = 0; i <= aw; i++) begin
      mem_addr_ok = (i == aw);
      mem_data_ok = (i != aw);
      mem_rdata   = 32'hBAD00000 | i;
      step;
    end
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    exp_req = 1'b0; exp_chk_fields = 1'b0;
    for (int j = 0; j <= dw; j++) begin
      mem_data_ok = (j == dw);
      mem_addr_ok = (j != dw);
      mem_rdata   = (j == dw) ? rdata : 32'hBAD10000;
      step;
    end
    mem_data_ok = 1'b0; mem_addr_ok = 1'b0; mem_rdata = 32'hBAD20000;
    exp_stall = 1'b0;
    if (wen == 4'd0) exp_rdata = model_load(rdata, addr, rwidth, rsign);
    for (int k = 0; k < ps; k++) begin
      pipe_stall = 1'b1;
      step;
    end
    pipe_stall = 1'b0;
    step;
    cpu_en = 1'b0;
  endtask

  int s0, r0;
  logic [31:0] lit;

  initial begin
    rst = 1'b1; cpu_en = 1'b1; cpu_wen = 4'd0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    cpu_rwidth = 4'd0; cpu_rsign = 1'b0; pipe_stall = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
    exp_stall = 1'b1; exp_req = 1'b0; exp_chk_fields = 1'b1;
    exp_wr = 1'b0; exp_size = 2'd0; exp_addr = 32'd0; exp_wdata = 32'd0; exp_rdata = 32'd0;
    step; step;
    chk_en = 1'b1;
    step;
    rst = 1'b0; cpu_en = 1'b0; exp_stall = 1'b0;
    step;
    exp_chk_fields = 1'b0;

    // word load, fastest handshake: stall is exactly three cycles
    s0 = stall_cycles;
    txn(4'd0, 32'h80001004, 32'h0, 4'hF, 1'b0, 0, 0, 32'h12345678, 0);
    check("word_stall_cycles", stall_cycles - s0, 3);
    check("word_rdata", cpu_rdata, 32'h12345678);

    // signed / unsigned byte, signed half
    txn(4'd0, 32'h80002003, 32'h0, 4'h1, 1'b1, 2, 1, 32'h80FFFFFF, 0);
`ifdef DATA_SRAM_BRIDGE_LOADEXT_EN
    lit = 32'hFFFFFF80;
`else
    lit = 32'h80FFFFFF;
`endif
    check("sbyte_rdata", cpu_rdata, lit);
    txn(4'd0, 32'h80002003, 32'h0, 4'h1, 1'b0, 0, 2, 32'h80FFFFFF, 0);
`ifdef DATA_SRAM_BRIDGE_LOADEXT_EN
    lit = 32'h00000080;
`endif
    check("ubyte_rdata", cpu_rdata, lit);
    txn(4'd0, 32'h80002002, 32'h0, 4'h3, 1'b1, 1, 0, 32'h8001FFFF, 0);
`ifdef DATA_SRAM_BRIDGE_LOADEXT_EN
    lit = 32'hFFFF8001;
`else
    lit = 32'h8001FFFF;
`endif
    check("shalf_rdata", cpu_rdata, lit);

    // store with addr_ok delayed 4 cycles: request held 5 cycles, rdata kept
    r0 = req_cycles;
    txn(4'hC, 32'h80003002, 32'hBEEFBEEF, 4'h0, 1'b0, 4, 0, 32'h77777777, 0);
    check("store_req_cycles", req_cycles - r0, 5);
    check("store_keeps_rdata", cpu_rdata, lit);

    // pipeline stall after completion, then back-to-back accesses
    r0 = req_cycles;
    txn(4'd0, 32'h80004000, 32'h0, 4'hF, 1'b0, 0, 0, 32'hCAFEF00D, 3);
    check("pstall_one_req", req_cycles - r0, 1);
    check("pstall_rdata", cpu_rdata, 32'hCAFEF00D);
    txn(4'd0, 32'h80004001, 32'h0, 4'h1, 1'b0, 0, 0, 32'hAABBCCDD, 0);
`ifdef DATA_SRAM_BRIDGE_LOADEXT_EN
    lit = 32'h000000CC;
`else
    lit = 32'hAABBCCDD;
`endif
    check("byte1_rdata", cpu_rdata, lit);
    txn(4'd0, 32'h80004000, 32'h0, 4'h3, 1'b0, 0, 1, 32'h1234F00F, 0);
    txn(4'd0, 32'h80004000, 32'h0, 4'h1, 1'b1, 0, 0, 32'h0000007F, 0);
    txn(4'h1, 32'h80005000, 32'h11111111, 4'h0, 1'b0, 1, 1, 32'h0, 0);
    txn(4'hF, 32'h80005004, 32'h22222222, 4'h0, 1'b0, 0, 0, 32'h0, 1);

    // reset while in the data phase, followed by a late data_ok
    cpu_en = 1'b1; cpu_wen = 4'd0; cpu_addr = 32'h80006000; cpu_wdata = 32'h0;
    cpu_rwidth = 4'hF; cpu_rsign = 1'b0;
    exp_stall = 1'b1; exp_req = 1'b0; exp_chk_fields = 1'b0;
    step;
    exp_req = 1'b1; exp_chk_fields = 1'b1; exp_wr = 1'b0; exp_size = 2'd2;
    exp_addr = 32'h80006000; exp_wdata = 32'h0;
    mem_addr_ok = 1'b1;
    step;
    mem_addr_ok = 1'b0; exp_req = 1'b0; exp_chk_fields = 1'b0;
    rst = 1'b1; cpu_en = 1'b0; exp_stall = 1'b0;
    step;
    rst = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h55AA55AA;
    exp_rdata = 32'd0; exp_chk_fields = 1'b1;
    exp_wr = 1'b0; exp_size = 2'd0; exp_addr = 32'd0; exp_wdata = 32'd0;
    step;
    mem_data_ok = 1'b0;
    step;
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    exp_chk_fields = 1'b0;

    // recovery after reset
    txn(4'd0, 32'h80007000, 32'h0, 4'hF, 1'b0, 0, 0, 32'h0BADF00D, 0);
    check("recover_rdata", cpu_rdata, 32'h0BADF00D);
    step;
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
